seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle, parametrised N-bit signed/unsigned ALU with a start/done handshake and a registered result. It is the clocked successor of the combinational add/sub/multiply/max unit. It adds min, unsigned multiply, an error flag for reserved opcodes and an iterative multiplier in place of the array multiplier. It sits between the UART command decoder, which issues operands and opcode, and the result serialiser, which consumes `Y` on `done`.

## Interface
- `N`, default 5: operand width in bits, N ≥ 2; result width is 2N.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `A`  in  N  operand A, two's complement except for op 101.
- `B`  in  N  operand B, same encoding as `A`.
- `op`  in  3  operation code: 000 add, 001 sub, 010 signed mul, 011 signed max, 100 signed min, 101 unsigned mul, 110/111 reserved.
- `busy`  out  1  high while a multiply is iterating; start is ignored while high.
- `done`  out  1  one-cycle pulse when `Y`/`err` update.
- `Y`  out  2N  registered result; held until the next `done`.
- `err`  out  1  registered, valid with `done`: 1 iff the op was reserved.

## Operation
- States: IDLE, MUL.
  - IDLE: `start`=1 latches `A`, `B` and `op` on the edge.
    - For ops other than 010/101: the result is computed from the latched values and written to `Y` on that same edge, with `done`=1 the following cycle; the state stays IDLE.
    - For ops 010/101: the state goes to MUL, `busy`=1, and the step counter loads N+1.
  - MUL: one radix-2 Booth step per cycle on (N+1)-bit operands. Op 010 sign-extends; op 101 zero-extends.
    - When the counter expires, the low 2N bits of the product go to `Y`, `done`=1, `busy`=0, and the state returns to IDLE.
- Arithmetic:
  - add/sub: (N+1)-bit exact result A±B, sign-extended to 2N. It never overflows.
  - mul: exact 2N-bit product. For op 010 it is signed; for op 101 it is unsigned, with A, B ∈ [0, 2^N−1].
  - max/min: signed compare; the selected operand is sign-extended to 2N. Equal operands return A.
  - reserved: `Y`=0 and `err`=1.
- `err`=0 for all defined ops and is updated only with `done`.
- `start` while `busy`=1 is ignored entirely. The latched operands and the counter are unchanged, and no queueing occurs.
- Operands and `op` may change freely after the accepting edge; the result depends only on the latched copy.
- Back-to-back: `start` is accepted in the same cycle `done` is high, because `busy`=0 there.

## Timing
- Reset: `Y`=0, `err`=0, `done`=0, `busy`=0, state IDLE, counter 0.
- `rst` mid-multiply aborts the operation. No `done` is produced, and `Y` returns to 0.
- `rst` takes priority over `start` in the same cycle.
- Latency is counted from the edge that samples `start`=1 to the first cycle with `done`=1:
  - add/sub/max/min/reserved: 1 cycle.
  - mul: N+2 cycles.
- `busy` rises in the cycle after the accepting edge and stays high for exactly N+1 cycles. It falls in the same cycle `done` rises.
- `done` is high for exactly one cycle per accepted request.
- Throughput:
  - ALU ops: one per cycle when `start` is held high; `done` then stays high continuously, with `Y` updating every cycle.
  - mul: one per N+2 cycles.
- `Y` is stable from the `done` cycle until the next `done`, or until reset.

## Test plan
All cases use N=5.
- Add/sub:
  - A=15, B=15, op=000 → `Y`=0x01E, `err`=0.
  - A=−16, B=15, op=001 → `Y`=0x3E1 (−31).
  - In both cases `done` is high 1 cycle after start.
- Signed mul:
  - A=−16, B=−16 → `Y`=0x100.
  - A=−16, B=15 → `Y`=0x310.
  - `busy` is high for 6 cycles and `done` comes at cycle 7.
- Unsigned mul: A=31, B=31, op=101 → `Y`=0x3C1. Also A=0, B=31 → `Y`=0x000.
- Max/min/reserved:
  - A=−3, B=2 → max `Y`=0x002, min `Y`=0x3FD.
  - A=B=−7 → min returns A, `Y`=0x3F9.
  - op=110 → `Y`=0, `err`=1, one `done` pulse.
- Handshake and ignored start:
  - Start a mul, then pulse `start` with op=000 while `busy`=1. Only the mul `done` occurs, with the correct product.
  - Assert `start` in the `done` cycle. The new request is accepted.
  - Hold `start` high with op=000 for 4 cycles. Four consecutive `done` cycles occur.
- Reset mid-mul: assert `rst` 3 cycles into a mul. The next cycle shows `busy`=0, `Y`=0 and `done`=0; no stale `done` ever appears, and a fresh add completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle N-bit ALU: single-cycle add/sub/max/min, iterative radix-2 Booth
// multiplier for signed/unsigned products, with start/done handshake and registered result.
module seq_alu #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic [2:0]     op,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Y,
  output logic           err,
  output logic           o_dbg_state
);

  localparam int CW = $clog2(N + 2);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  // Handshake: a request is taken on any rising edge where start=1 and busy=0;
  // done is a one-cycle pulse in the cycle after Y/err were written.
  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_last;

  logic [2*N-1:0]  r_y;
  logic            r_err;
  logic            r_done;
  logic [CW-1:0]   r_cnt;
  logic [N+1:0]    r_acc;
  logic [N+1:0]    r_m;
  logic [N:0]      r_q;
  logic            r_qm1;

  logic [N:0]      w_a_x;
  logic [N:0]      w_b_x;
  logic [N:0]      w_sum;
  logic [N:0]      w_diff;
  logic            w_a_ge_b;
  logic            w_a_le_b;
  logic [2*N-1:0]  w_alu_y;
  logic            w_alu_err;
  logic            w_is_mul;
  logic            w_sext;
  logic [N+1:0]    w_acc_sum;
  logic [N+1:0]    w_acc_sh;
  logic [N:0]      w_q_sh;

  assign busy        = (r_state == S_MUL);
  assign done        = r_done;
  assign Y           = r_y;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  // Single-cycle datapath, evaluated on the live inputs at the accepting edge.
  assign w_a_x     = {A[N-1], A};
  assign w_b_x     = {B[N-1], B};
  assign w_sum     = w_a_x + w_b_x;
  assign w_diff    = w_a_x - w_b_x;
  assign w_a_ge_b  = ($signed(A) >= $signed(B));
  assign w_a_le_b  = ($signed(A) <= $signed(B));
  assign w_is_mul  = (op == 3'b010) || (op == 3'b101);
  assign w_sext    = (op == 3'b010);
  assign w_alu_err = op[2] & op[1];

  always_comb begin
    w_alu_y = '0;
    case (op)
      3'b000:  w_alu_y = {{(N-1){w_sum[N]}}, w_sum};
      3'b001:  w_alu_y = {{(N-1){w_diff[N]}}, w_diff};
      3'b011:  w_alu_y = w_a_ge_b ? {{N{A[N-1]}}, A} : {{N{B[N-1]}}, B};
      3'b100:  w_alu_y = w_a_le_b ? {{N{A[N-1]}}, A} : {{N{B[N-1]}}, B};
      default: w_alu_y = '0;
    endcase
  end

  // Booth step; the accumulator carries one guard bit so add/sub never wraps.
  always_comb begin
    w_acc_sum = r_acc;
    case ({r_q[0], r_qm1})
      2'b01:   w_acc_sum = r_acc + r_m;
      2'b10:   w_acc_sum = r_acc - r_m;
      default: w_acc_sum = r_acc;
    endcase
  end

  assign w_acc_sh = {w_acc_sum[N+1], w_acc_sum[N+1:1]};
  assign w_q_sh   = {w_acc_sum[0], r_q[N:1]};

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (w_is_mul) w_next = S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == CW'(1)) begin
          w_last = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y    <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_qm1  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_is_mul) begin
          r_acc <= '0;
          r_m   <= {{2{w_sext & A[N-1]}}, A};
          r_q   <= {w_sext & B[N-1], B};
          r_qm1 <= 1'b0;
          r_cnt <= CW'(N + 1);
        end else begin
          r_y    <= w_alu_y;
          r_err  <= w_alu_err;
          r_done <= 1'b1;
        end
      end else if (r_state == S_MUL) begin
        r_acc <= w_acc_sh;
        r_q   <= w_q_sh;
        r_qm1 <= r_q[0];
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_y    <= {w_acc_sh[N-2:0], w_q_sh};
          r_err  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (N=5): results, latency, busy length, handshake
// corner cases and reset abort, checked against hand-computed values.
module tb_seq_alu;

  localparam int N = 5;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [2:0]     op;
  logic           busy;
  logic           done;
  logic [2*N-1:0] y;
  logic           err;
  logic           dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*N-1:0] exp_q[$];

  seq_alu #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .op(op),
    .busy(busy), .done(done), .Y(y), .err(err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, scramble inputs after acceptance, then wait for done.
  task automatic do_op(input string tag, input logic [N-1:0] ia, input logic [N-1:0] ib,
                       input logic [2:0] iop, input logic [2*N-1:0] exp_y,
                       input logic exp_err, input int exp_lat, input int exp_busy);
    int lat;
    int nbusy;
    a = ia; b = ib; op = iop; start = 1'b1;
    tick();
    start = 1'b0;
    a = N'($urandom_range(0, 31));
    b = N'($urandom_range(0, 31));
    op = 3'($urandom_range(0, 7));
    lat = 1;
    nbusy = 0;
    while (!done && lat < 20) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check({tag, "_busy"}, 16'(nbusy), 16'(exp_busy));
    check({tag, "_y"}, 16'(y), 16'(exp_y));
    check({tag, "_err"}, 16'(err), 16'(exp_err));
    if (exp_lat > 1) check({tag, "_busy_fall"}, 16'(busy), 16'd0);
  endtask

  initial begin
    int ndone;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
    tick(); tick();
    check("rst_y", 16'(y), 16'h0);
    check("rst_err", 16'(err), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    rst = 1'b0;
    tick();

    do_op("add", 5'd15, 5'd15, 3'b000, 10'h01E, 1'b0, 1, 0);
    do_op("sub", 5'h10, 5'h0F, 3'b001, 10'h3E1, 1'b0, 1, 0);
    do_op("smul_nn", 5'h10, 5'h10, 3'b010, 10'h100, 1'b0, 7, 6);
    do_op("smul_np", 5'h10, 5'h0F, 3'b010, 10'h310, 1'b0, 7, 6);
    do_op("umul_max", 5'd31, 5'd31, 3'b101, 10'h3C1, 1'b0, 7, 6);
    do_op("umul_zero", 5'd0, 5'd31, 3'b101, 10'h000, 1'b0, 7, 6);
    do_op("max", 5'h1D, 5'h02, 3'b011, 10'h002, 1'b0, 1, 0);
    do_op("min", 5'h1D, 5'h02, 3'b100, 10'h3FD, 1'b0, 1, 0);
    do_op("min_eq", 5'h19, 5'h19, 3'b100, 10'h3F9, 1'b0, 1, 0);
    do_op("rsvd", 5'd3, 5'd4, 3'b110, 10'h000, 1'b1, 1, 0);
    do_op("err_clr", 5'd1, 5'd2, 3'b000, 10'h003, 1'b0, 1, 0);

    // start during busy must be ignored
    a = 5'd3; b = 5'd5; op = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 5'd1; b = 5'd1; op = 3'b000; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        check("ign_y", 16'(y), 16'h00F);
      end
      tick();
    end
    check("ign_ndone", 16'(ndone), 16'd1);

    // new start accepted in the done cycle
    a = 5'd2; b = 5'd3; op = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) tick();
    check("b2b_mul_y", 16'(y), 16'h006);
    a = 5'd4; b = 5'd5; op = 3'b000; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_done", 16'(done), 16'd1);
    check("b2b_y", 16'(y), 16'h009);
    tick();

    // start held high: one result per cycle through an expected queue
    exp_q.push_back(10'h003);
    exp_q.push_back(10'h3FE);
    exp_q.push_back(10'h3FF);
    exp_q.push_back(10'h3E0);
    op = 3'b000;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin a = 5'd1;  b = 5'd2;  end
        1: begin a = 5'h1F; b = 5'h1F; end
        2: begin a = 5'd7;  b = 5'h18; end
        default: begin a = 5'h10; b = 5'h10; end
      endcase
      start = 1'b1;
      tick();
      check("hold_done", 16'(done), 16'd1);
      check("hold_y", 16'(y), 16'(exp_q.pop_front()));
    end
    start = 1'b0;
    tick();
    check("hold_end_done", 16'(done), 16'd0);

    // reset three cycles into a multiply
    a = 5'd5; b = 5'd5; op = 3'b010; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_y", 16'(y), 16'h000);
    check("abort_done", 16'(done), 16'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      tick();
    end
    check("abort_no_done", 16'(ndone), 16'd0);
    do_op("post_rst_add", 5'd6, 5'd9, 3'b000, 10'h00F, 1'b0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
